lookup_tcam: RTL and testbench
==============================

LOOKUP_TCAM -- requirements
Module: lookup_tcam

Interface
REQ-001 SHALL have parameter PHV_LEN, default 48*8+32*8+16*8+5*20+256 (1124): PHV width.
REQ-002 SHALL have parameter KEY_LEN, default 197: key width.
REQ-003 SHALL have parameter DEPTH, default 16: table entries; AXIL_WIDTH, default 32: config word width.
REQ-004 SHALL have port clk, input, 1: sole clock, rising edge.
REQ-005 SHALL have port rst, input, 1: reset, asynchronous, active-high.
REQ-006 SHALL have ports phv_in (input, PHV_LEN), phv_valid_in (input, 1), key_in (input, KEY_LEN) and key_valid_in (input, 1): PHV and key from key extract, aligned in the same cycle.
REQ-007 SHALL have config inputs: cfg_data (AXIL_WIDTH), cfg_valid (1), cfg_entry (4, entry index), cfg_word (4, word index 0..13) and cfg_inv (1, invalidate cfg_entry).
REQ-008 SHALL have outputs phv_out (PHV_LEN), phv_valid_out (1), hit (1), action_addr (4) and lookup_valid (1).
REQ-009 SHALL have outputs hit_cnt (32), miss_cnt (32) and input stats_clr (1).

Function
REQ-010 Entry = key (words 0-6, 224b, low KEY_LEN bits used) + mask (words 7-13); word w lands in staging bits [32w+31:32w]; mask bit 1 = compare, 0 = don't care.
REQ-011 Word 13 write SHALL commit staging key/mask to cfg_entry, set its valid bit, and take effect for comparisons from the next cycle.
REQ-012 cfg_word > 13 SHALL be ignored; cfg_inv clears the valid bit of cfg_entry next cycle; cfg_inv wins over a same-cycle commit to that entry.
REQ-013 Stage 1: register key/PHV/valids; entry i matches iff valid_i and ((key ^ key_i) & mask_i) == 0, against the table contents of that cycle.
REQ-014 Stage 2: register match vector priority result: hit = any match; action_addr = lowest matching index, 0 on miss.
REQ-015 Latency SHALL be exactly 2 cycles from key_valid_in to lookup_valid; back-to-back lookups every cycle; no stall.
REQ-016 phv_out/phv_valid_out SHALL be phv_in/phv_valid_in delayed 2 cycles, same cycle as lookup_valid.
REQ-017 hit/action_addr SHALL hold their last value while lookup_valid is 0.
REQ-018 All-zero mask on a valid entry SHALL match every key.

Reset
REQ-019 rst SHALL clear all outputs to 0, all entry valid bits, staging buffer, and pipeline valids; in-flight lookups are dropped, not emitted.
REQ-020 Table key/mask storage need not be cleared; only valid bits gate matching.

Configuration
REQ-021 With LKP_STATS_EN defined, hit_cnt/miss_cnt SHALL increment on each lookup_valid with hit=1/0, saturate at 0xFFFFFFFF, and clear on stats_clr (clear wins over increment).
REQ-022 Without LKP_STATS_EN, hit_cnt and miss_cnt SHALL be constant 0 and no counter logic is built; stats_clr is ignored.

Structure
REQ-023 Shared package lkp_pkg SHALL hold KEY_LEN, DEPTH, CFG_WORDS=14, KEY_WORDS=7 and the entry-index width.
REQ-024 The priority encoder SHALL be sub-module lkp_prio_enc (DEPTH-bit vector in, hit + index out, combinational).

Verification
REQ-025 Write entry 3 key=0x1234 (low bits), mask=0xFFFF, commit; key_in=0x1234 -> 2 cycles later lookup_valid=1, hit=1, action_addr=3.
REQ-026 Entries 2 and 5 both match key 0xABCD -> action_addr=2; invalidate entry 2 -> next lookup returns action_addr=5.
REQ-027 Empty table, 10 back-to-back lookups -> 10 consecutive lookup_valid pulses with hit=0, phv_out matching phv_in of 2 cycles earlier; with LKP_STATS_EN, miss_cnt=10.
REQ-028 Commit word 13 in cycle N with a matching key in cycle N -> miss; the same key in cycle N+1 -> hit.
REQ-029 Assert rst with 2 lookups in flight -> no lookup_valid after rst; all outputs 0; a previously committed entry no longer hits.
REQ-030 With LKP_STATS_EN, force hit_cnt to 0xFFFFFFFF, then perform another hit -> value holds; stats_clr in the same cycle as a hit -> 0.

Source files
------------

// File: rtl/lkp_pkg.sv
// Shared constants for the lookup_tcam match pipeline: key geometry,
// table depth and configuration word layout.
package lkp_pkg;

   localparam int KEY_LEN   = 197;
   localparam int DEPTH     = 16;
   localparam int CFG_WORDS = 14;
   localparam int KEY_WORDS = 7;
   localparam int IDX_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   typedef logic [IDX_W-1:0] idx_t;

endpackage

// File: rtl/lkp_prio_enc.sv
// Combinational priority encoder: reports whether any bit is set and the
// index of the lowest set bit (0 when none is set).
module lkp_prio_enc
   import lkp_pkg::*;
#(
   parameter int N  = DEPTH,
   parameter int IW = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]  vec_i,
   output logic          hit_o,
   output logic [IW-1:0] idx_o
);

   always_comb begin
      // NOTE: every output gets a default before the loop, so no path infers a latch.
      hit_o = |vec_i;
      idx_o = '0;
      // Scanning downwards lets the lowest set bit overwrite the rest.
      for (int i = N - 1; i >= 0; i--) begin
         if (vec_i[i]) idx_o = IW'(i);
      end
   end

endmodule

// File: rtl/lookup_tcam.sv
// Two-stage ternary match table: stage 1 registers the match vector, stage 2
// registers the priority result. Define LKP_STATS_EN to build hit/miss counters.
module lookup_tcam #(
   parameter int PHV_LEN    = 48*8+32*8+16*8+5*20+256,
   parameter int KEY_LEN    = lkp_pkg::KEY_LEN,
   parameter int DEPTH      = lkp_pkg::DEPTH,
   parameter int AXIL_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  rst,

   input  logic [PHV_LEN-1:0]    phv_in,
   input  logic                  phv_valid_in,
   input  logic [KEY_LEN-1:0]    key_in,
   input  logic                  key_valid_in,

   input  logic [AXIL_WIDTH-1:0] cfg_data,
   input  logic                  cfg_valid,
   input  logic [3:0]            cfg_entry,
   input  logic [3:0]            cfg_word,
   input  logic                  cfg_inv,

   output logic [PHV_LEN-1:0]    phv_out,
   output logic                  phv_valid_out,
   output logic                  hit,
   output logic [3:0]            action_addr,
   output logic                  lookup_valid,

   output logic [31:0]           hit_cnt,
   output logic [31:0]           miss_cnt,
   input  logic                  stats_clr
);

   import lkp_pkg::CFG_WORDS;
   import lkp_pkg::KEY_WORDS;

   localparam int IW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int STG_W   = CFG_WORDS * AXIL_WIDTH;
   localparam int MSK_LSB = KEY_WORDS * AXIL_WIDTH;

   // ---------------- configuration staging and table ----------------
   logic [STG_W-1:0]   stage_q, stage_d;
   logic [DEPTH-1:0]   valid_q, valid_d;
   logic               word_ok, commit, entry_ok;
   logic [IW-1:0]      entry_idx;

   logic [KEY_LEN-1:0] key_mem  [DEPTH];
   logic [KEY_LEN-1:0] mask_mem [DEPTH];

   assign word_ok   = cfg_valid && (int'(cfg_word) < CFG_WORDS);
   assign commit    = word_ok && (int'(cfg_word) == CFG_WORDS - 1);
   assign entry_ok  = int'(cfg_entry) < DEPTH;
   assign entry_idx = IW'(cfg_entry);

   always_comb begin
      stage_d = stage_q;
      if (word_ok) stage_d[int'(cfg_word)*AXIL_WIDTH +: AXIL_WIDTH] = cfg_data;

      valid_d = valid_q;
      if (commit && entry_ok)  valid_d[entry_idx] = 1'b1;
      // Invalidate is applied last so it overrides a same-cycle commit.
      if (cfg_inv && entry_ok) valid_d[entry_idx] = 1'b0;
   end

   // NOTE: sequential state uses <= so every flop samples pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stage_q <= '0;
         valid_q <= '0;
      end else begin
         stage_q <= stage_d;
         valid_q <= valid_d;
      end
   end

   // NOTE: key/mask storage has no reset; valid_q alone gates matching.
   always_ff @(posedge clk) begin
      if (commit && entry_ok) begin
         key_mem[entry_idx]  <= stage_d[KEY_LEN-1:0];
         mask_mem[entry_idx] <= stage_d[MSK_LSB +: KEY_LEN];
      end
   end

   // ---------------- stage 1: match against current table ----------------
   logic [DEPTH-1:0]   match_d, match_q;
   logic [PHV_LEN-1:0] s1_phv_q;
   logic               s1_pv_q, s1_kv_q;

   always_comb begin
      match_d = '0;
      for (int i = 0; i < DEPTH; i++) begin
         match_d[i] = key_valid_in && valid_q[i] &&
                      (((key_in ^ key_mem[i]) & mask_mem[i]) == '0);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         match_q  <= '0;
         s1_phv_q <= '0;
         s1_pv_q  <= 1'b0;
         s1_kv_q  <= 1'b0;
      end else begin
         match_q  <= match_d;
         s1_phv_q <= phv_in;
         s1_pv_q  <= phv_valid_in;
         s1_kv_q  <= key_valid_in;
      end
   end

   // ---------------- stage 2: priority result ----------------
   logic               enc_hit;
   logic [IW-1:0]      enc_idx;
   logic [PHV_LEN-1:0] phv_q;
   logic               phv_valid_q, lookup_valid_q, hit_q;
   logic [3:0]         addr_q;

   lkp_prio_enc #(
      .N  (DEPTH),
      .IW (IW)
   ) u_prio_enc (
      .vec_i (match_q),
      .hit_o (enc_hit),
      .idx_o (enc_idx)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         phv_q          <= '0;
         phv_valid_q    <= 1'b0;
         lookup_valid_q <= 1'b0;
         hit_q          <= 1'b0;
         addr_q         <= '0;
      end else begin
         phv_q          <= s1_phv_q;
         phv_valid_q    <= s1_pv_q;
         lookup_valid_q <= s1_kv_q;
         if (s1_kv_q) begin
            hit_q  <= enc_hit;
            addr_q <= 4'(enc_idx);
         end
      end
   end

   assign phv_out       = phv_q;
   assign phv_valid_out = phv_valid_q;
   assign lookup_valid  = lookup_valid_q;
   assign hit           = hit_q;
   assign action_addr   = addr_q;

   // ---------------- optional statistics ----------------
`ifdef LKP_STATS_EN
   logic [31:0] hit_cnt_q, miss_cnt_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         hit_cnt_q  <= '0;
         miss_cnt_q <= '0;
      end else if (stats_clr) begin
         hit_cnt_q  <= '0;
         miss_cnt_q <= '0;
      end else if (lookup_valid_q) begin
         if (hit_q && (hit_cnt_q != '1))    hit_cnt_q  <= hit_cnt_q + 32'd1;
         if (!hit_q && (miss_cnt_q != '1))  miss_cnt_q <= miss_cnt_q + 32'd1;
      end
   end

   assign hit_cnt  = hit_cnt_q;
   assign miss_cnt = miss_cnt_q;
`else
   logic unused_stats_clr;

   assign unused_stats_clr = stats_clr;
   assign hit_cnt          = '0;
   assign miss_cnt         = '0;
`endif

endmodule

// File: tb/tb_lookup_tcam.sv
// Self-checking bench for lookup_tcam: table-driven lookups plus hand-written
// corner sequences, scored against a queue of expected results.
module tb_lookup_tcam;

   localparam int PHV_LEN = 1124;
   localparam int KEY_LEN = 197;

   typedef struct packed {
      logic       v;
      logic [3:0] entry;
      logic [3:0] word;
      logic [31:0] data;
      logic       inv;
      logic       sclr;
   } cfg_t;

   typedef struct {
      logic               hit;
      logic [3:0]         addr;
      logic [PHV_LEN-1:0] phv;
      int                 cyc;
   } exp_t;

   typedef struct {
      logic [KEY_LEN-1:0] key;
      logic               hit;
      logic [3:0]         addr;
   } vec_t;

   localparam cfg_t NOCFG = '0;
   localparam logic [223:0] M16 = 224'hFFFF;

   logic               clk = 1'b0;
   logic               rst = 1'b1;
   logic [PHV_LEN-1:0] phv_in = '0;
   logic               phv_valid_in = 1'b0;
   logic [KEY_LEN-1:0] key_in = '0;
   logic               key_valid_in = 1'b0;
   logic [31:0]        cfg_data = '0;
   logic               cfg_valid = 1'b0;
   logic [3:0]         cfg_entry = '0;
   logic [3:0]         cfg_word = '0;
   logic               cfg_inv = 1'b0;
   logic               stats_clr = 1'b0;

   logic [PHV_LEN-1:0] phv_out;
   logic               phv_valid_out, hit, lookup_valid;
   logic [3:0]         action_addr;
   logic [31:0]        hit_cnt, miss_cnt;

   int n_cmp = 0;
   int n_bad = 0;
   int cyc = 0;

   exp_t        sb[$];
   exp_t        e;
   logic        last_hit = 1'b0;
   logic [3:0]  last_addr = '0;
   logic [31:0] exp_hits = '0;
   logic [31:0] exp_misses = '0;
   vec_t        vecs[10];

   lookup_tcam #(
      .PHV_LEN    (PHV_LEN),
      .KEY_LEN    (KEY_LEN),
      .DEPTH      (16),
      .AXIL_WIDTH (32)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .phv_in        (phv_in),
      .phv_valid_in  (phv_valid_in),
      .key_in        (key_in),
      .key_valid_in  (key_valid_in),
      .cfg_data      (cfg_data),
      .cfg_valid     (cfg_valid),
      .cfg_entry     (cfg_entry),
      .cfg_word      (cfg_word),
      .cfg_inv       (cfg_inv),
      .phv_out       (phv_out),
      .phv_valid_out (phv_valid_out),
      .hit           (hit),
      .action_addr   (action_addr),
      .lookup_valid  (lookup_valid),
      .hit_cnt       (hit_cnt),
      .miss_cnt      (miss_cnt),
      .stats_clr     (stats_clr)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic cfg_t mk_cfg(input logic v, input int entry, input int word,
                                   input logic [31:0] data, input logic inv, input logic sclr);
      cfg_t c;
      c.v = v; c.entry = 4'(entry); c.word = 4'(word);
      c.data = data; c.inv = inv; c.sclr = sclr;
      return c;
   endfunction

   function automatic logic [PHV_LEN-1:0] rand_phv();
      logic [36*32-1:0] t;
      for (int i = 0; i < 36; i++) t[i*32 +: 32] = $urandom();
      return t[PHV_LEN-1:0];
   endfunction

   // One clock of stimulus; a lookup pushes its expected result.
   task automatic step(input logic lk, input logic [KEY_LEN-1:0] key,
                       input logic eh, input logic [3:0] ea, input cfg_t c);
      exp_t x;
      @(posedge clk);
      #1;
      key_valid_in = lk;
      phv_valid_in = lk;
      key_in       = key;
      phv_in       = rand_phv();
      cfg_valid    = c.v;
      cfg_entry    = c.entry;
      cfg_word     = c.word;
      cfg_data     = c.data;
      cfg_inv      = c.inv;
      stats_clr    = c.sclr;
      if (lk) begin
         x.hit = eh; x.addr = ea; x.phv = phv_in; x.cyc = cyc;
         sb.push_back(x);
      end
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, '0, 1'b0, 4'd0, NOCFG);
   endtask

   task automatic write_words(input int idx, input logic [223:0] key,
                              input logic [223:0] mask, input int last);
      logic [31:0] d;
      for (int w = 0; w <= last; w++) begin
         d = (w < 7) ? key[w*32 +: 32] : mask[(w-7)*32 +: 32];
         step(1'b0, '0, 1'b0, 4'd0, mk_cfg(1'b1, idx, w, d, 1'b0, 1'b0));
      end
   endtask

   task automatic check_stats();
`ifdef LKP_STATS_EN
      check("hit_cnt", 64'(hit_cnt), 64'(exp_hits));
      check("miss_cnt", 64'(miss_cnt), 64'(exp_misses));
`else
      check("hit_cnt_tied", 64'(hit_cnt), 64'd0);
      check("miss_cnt_tied", 64'(miss_cnt), 64'd0);
`endif
   endtask

   // Output monitor: pops on every lookup_valid, otherwise checks hold.
   always @(negedge clk) begin
      if (lookup_valid) begin
         if (sb.size() == 0) begin
            check("unexpected_lookup_valid", 64'd1, 64'd0);
         end else begin
            e = sb.pop_front();
            check("latency", 64'(cyc - e.cyc), 64'd2);
            check("hit", 64'(hit), 64'(e.hit));
            check("action_addr", 64'(action_addr), 64'(e.addr));
            check("phv_valid_out", 64'(phv_valid_out), 64'd1);
            check("phv_out_bits_differing", 64'($countones(phv_out ^ e.phv)), 64'd0);
            last_hit  = e.hit;
            last_addr = e.addr;
            if (e.hit && exp_hits != '1)    exp_hits++;
            if (!e.hit && exp_misses != '1) exp_misses++;
         end
      end else begin
         check("idle_hold", 64'({phv_valid_out, hit, action_addr}),
               64'({1'b0, last_hit, last_addr}));
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: run did not finish, cycle %0d", cyc);
      $fatal(1, "watchdog expired");
   end

   initial begin
      vecs[0] = '{197'hABCD, 1'b1, 4'd2};
      vecs[1] = '{197'h1234, 1'b1, 4'd3};
      vecs[2] = '{{1'b1, 196'h0}, 1'b1, 4'd4};
      vecs[3] = '{{1'b1, 180'h0, 16'h1234}, 1'b1, 4'd3};
      vecs[4] = '{197'h0, 1'b0, 4'd0};
      vecs[5] = '{197'hF0, 1'b1, 4'd7};
      vecs[6] = '{197'hFFF5, 1'b1, 4'd7};
      vecs[7] = '{197'hABCE, 1'b0, 4'd0};
      vecs[8] = '{{1'b1, 180'h0, 16'hABCD}, 1'b1, 4'd2};
      vecs[9] = '{197'h1235, 1'b0, 4'd0};

      // Reset state
      repeat (2) @(negedge clk);
      check("reset_ctrl", 64'({lookup_valid, phv_valid_out, hit, action_addr}), 64'd0);
      check("reset_phv_out_ones", 64'($countones(phv_out)), 64'd0);
      check_stats();
      @(posedge clk);
      #1 rst = 1'b0;

      // Empty table, back-to-back lookups all miss
      for (int i = 0; i < 10; i++) step(1'b1, 197'($urandom()), 1'b0, 4'd0, NOCFG);
      idle(3);
      check("empty_sb_drained", 64'(sb.size()), 64'd0);
      check_stats();

      // Single exact entry
      write_words(3, 224'h1234, M16, 13);
      step(1'b1, 197'h1234, 1'b1, 4'd3, NOCFG);
      idle(3);

      // Overlapping entries, partial mask, full-width mask
      write_words(2, 224'hABCD, M16, 13);
      write_words(5, 224'hABCD, M16, 13);
      write_words(7, 224'hF0, 224'hF0, 13);
      write_words(4, {27'h0, 1'b1, 196'h0}, '1, 13);
      for (int i = 0; i < 10; i++) step(1'b1, vecs[i].key, vecs[i].hit, vecs[i].addr, NOCFG);
      idle(3);

      // Invalidate the lower of two matches
      step(1'b0, '0, 1'b0, 4'd0, mk_cfg(1'b0, 2, 0, 32'h0, 1'b1, 1'b0));
      step(1'b1, 197'hABCD, 1'b1, 4'd5, NOCFG);
      idle(3);

      // Out-of-range word indices are ignored
      write_words(6, 224'h5555, M16, 12);
      step(1'b0, '0, 1'b0, 4'd0, mk_cfg(1'b1, 6, 14, 32'hFFFF_FFFF, 1'b0, 1'b0));
      step(1'b0, '0, 1'b0, 4'd0, mk_cfg(1'b1, 6, 15, 32'hFFFF_FFFF, 1'b0, 1'b0));
      step(1'b1, 197'h5555, 1'b0, 4'd0, NOCFG);
      step(1'b0, '0, 1'b0, 4'd0, mk_cfg(1'b1, 6, 13, 32'h0, 1'b0, 1'b0));
      step(1'b1, 197'h5555, 1'b1, 4'd6, NOCFG);
      idle(3);

      // Commit and lookup in the same cycle: miss, next cycle: hit
      write_words(10, 224'h7777, M16, 12);
      step(1'b1, 197'h7777, 1'b0, 4'd0, mk_cfg(1'b1, 10, 13, 32'h0, 1'b0, 1'b0));
      step(1'b1, 197'h7777, 1'b1, 4'd10, NOCFG);
      idle(3);

      // Invalidate beats a same-cycle commit to the same entry
      write_words(11, 224'h3C3C, M16, 12);
      step(1'b0, '0, 1'b0, 4'd0, mk_cfg(1'b1, 11, 13, 32'h0, 1'b1, 1'b0));
      step(1'b1, 197'h3C3C, 1'b0, 4'd0, NOCFG);
      idle(3);

      // All-zero mask matches every key
      write_words(12, 224'h9999, 224'h0, 13);
      step(1'b1, 197'h3C3C, 1'b1, 4'd12, NOCFG);
      step(1'b1, 197'h1234, 1'b1, 4'd3, NOCFG);
      step(1'b1, {1'b1, 196'h5A5A}, 1'b1, 4'd12, NOCFG);
      step(1'b0, '0, 1'b0, 4'd0, mk_cfg(1'b0, 12, 0, 32'h0, 1'b1, 1'b0));
      step(1'b1, 197'h0, 1'b0, 4'd0, NOCFG);
      idle(3);
      check_stats();

`ifdef LKP_STATS_EN
      // Saturation, then clear in the same cycle as a hit result
      force dut.hit_cnt_q = 32'hFFFF_FFFF;
      idle(1);
      release dut.hit_cnt_q;
      exp_hits = 32'hFFFF_FFFF;
      step(1'b1, 197'h1234, 1'b1, 4'd3, NOCFG);
      idle(3);
      check_stats();
      step(1'b1, 197'h1234, 1'b1, 4'd3, NOCFG);
      idle(1);
      step(1'b0, '0, 1'b0, 4'd0, mk_cfg(1'b0, 0, 0, 32'h0, 1'b0, 1'b1));
      idle(1);
      exp_hits   = '0;
      exp_misses = '0;
      check_stats();
`endif

      // Reset with two lookups in flight
      step(1'b1, 197'h1234, 1'b1, 4'd3, NOCFG);
      step(1'b1, 197'hABCD, 1'b1, 4'd5, NOCFG);
      #2;
      rst          = 1'b1;
      key_valid_in = 1'b0;
      phv_valid_in = 1'b0;
      sb.delete();
      last_hit   = 1'b0;
      last_addr  = '0;
      exp_hits   = '0;
      exp_misses = '0;
      @(negedge clk);
      check("rst_ctrl", 64'({lookup_valid, phv_valid_out, hit, action_addr}), 64'd0);
      check("rst_phv_out_ones", 64'($countones(phv_out)), 64'd0);
      check_stats();
      idle(3);
      @(posedge clk);
      #1 rst = 1'b0;
      step(1'b1, 197'h1234, 1'b0, 4'd0, NOCFG);
      idle(4);

      check("final_sb_drained", 64'(sb.size()), 64'd0);
      check_stats();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
